// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    typedef enum logic {
        FETCH_RUN,
        FETCH_DRAIN
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous prefetch FIFO: power-of-two depth, fall-through head, single-cycle flush.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop && !empty && !flush;
    assign do_push   = push && !flush && (!full || do_pop);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // NOTE: the storage array has no reset; count and pointers alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, in-order prefetch buffer,
// redirect flush with discard of stale in-flight responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 2;

    fetch_state_t  state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   rsp_pc, rsp_pc_next;
    logic [CW-1:0] outstanding, outstanding_next;
    logic [CW-1:0] drop_cnt, drop_cnt_next;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] credit_used;
    logic          fifo_full, fifo_empty;
    logic          req_fire, push, pop, drop_rsp;
    fetch_entry_t  push_entry, head_entry;

    // Every buffered word, live request and stale request holds one credit.
    assign credit_used    = SW'(fifo_count) + SW'(outstanding) + SW'(drop_cnt);
    assign imem_req_valid = !reset && !redirect_valid && !fifo_full
                            && (credit_used < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push       = imem_rsp_valid && (state == FETCH_RUN) && !redirect_valid;
    assign drop_rsp   = imem_rsp_valid && (state == FETCH_DRAIN) && !redirect_valid;
    assign pop        = instr_valid && instr_ready && !redirect_valid;
    assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (head_entry)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? 32'h0 : head_entry.instr;
    assign instr_pc    = fifo_empty ? 32'h0 : head_entry.pc;

    // outstanding counts only live requests; a redirect turns all of them stale (drop_cnt).
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        rsp_pc_next      = rsp_pc;
        outstanding_next = outstanding;
        drop_cnt_next    = drop_cnt;

        if (redirect_valid) begin
            fetch_pc_next    = word_align(redirect_pc);
            rsp_pc_next      = word_align(redirect_pc);
            outstanding_next = '0;
            drop_cnt_next    = outstanding + drop_cnt - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_next = fetch_pc + 32'd4;
            if (push)     rsp_pc_next   = rsp_pc + 32'd4;
            outstanding_next = outstanding + CW'(req_fire) - CW'(push);
            if (drop_rsp) drop_cnt_next = drop_cnt - CW'(1);
        end

        state_next = (drop_cnt_next != '0) ? FETCH_DRAIN : FETCH_RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH_RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            rsp_pc      <= rsp_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with programmable latency and a
// scoreboard of expected {pc, instr} pairs, compared as the core consumes them.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_req_t;

    mem_req_t     mem_q[$];
    mem_req_t     cur_rsp;
    fetch_entry_t exp_q[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          rel_cyc = 0;
    int          first_req_cyc = -1;
    int          first_val_cyc = -1;
    int          fires = 0;
    int          bad_fires = 0;
    logic [31:0] model_pc;
    logic [31:0] first_pop_pc;
    bit          first_pop_seen;
    bit          rst_applied = 1'b0;
    bit          last_req_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic mark();
        first_pop_seen = 1'b0;
        first_pop_pc   = 32'hDEAD_BEEF;
        fires          = 0;
        bad_fires      = 0;
    endtask

    // One clock cycle: observe at the falling edge, update models, drive memory after the rising edge.
    task automatic step();
        fetch_entry_t e;
        @(negedge clk);
        if (reset) begin
            check("rst_req_valid", 32'(imem_req_valid), 0);
            if (rst_applied) begin
                check("rst_instr_valid", 32'(instr_valid), 0);
                check("rst_instr", instr, 0);
                check("rst_instr_pc", instr_pc, 0);
            end
            model_pc = RESET_PC;
            exp_q.delete();
            mem_q.delete();
            epoch++;
        end else begin
            check("inv_count_le_depth", 32'(dut.fifo_count <= DEPTH), 1);
            check("inv_credit_le_depth",
                  32'((int'(dut.fifo_count) + int'(dut.outstanding) + int'(dut.drop_cnt)) <= DEPTH), 1);
            if (imem_rsp_valid)
                check("inv_rsp_with_credit", 32'((int'(dut.outstanding) + int'(dut.drop_cnt)) != 0), 1);

            check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            if (!instr_valid) begin
                check("empty_instr", instr, 0);
                check("empty_instr_pc", instr_pc, 0);
            end else if (instr_ready && !redirect_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pop_pc", instr_pc, e.pc);
                check("pop_instr", instr, e.instr);
                if (!first_pop_seen) begin
                    first_pop_seen = 1'b1;
                    first_pop_pc   = instr_pc;
                end
            end
            if (instr_valid && first_val_cyc < 0) first_val_cyc = cyc;

            if (imem_rsp_valid && !redirect_valid && cur_rsp.epoch == epoch)
                exp_q.push_back('{pc: cur_rsp.addr, instr: imem_rsp_data});

            if (redirect_valid) check("no_req_on_redirect", 32'(imem_req_valid), 0);
            if (imem_req_valid) begin
                check("req_addr", imem_req_addr, model_pc);
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back('{addr: imem_req_addr, due: cyc + lat, epoch: epoch});
                model_pc = model_pc + 32'd4;
                fires++;
                if (imem_req_addr[31:8] == 24'h2) bad_fires++;
            end
            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                model_pc = {redirect_pc[31:2], 2'b00};
            end
        end
        last_req_valid = imem_req_valid;

        @(posedge clk);
        rst_applied = reset;
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (!reset && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            cur_rsp        = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(cur_rsp.addr);
        end
    endtask

    // Memory shares the reset and abandons everything in flight.
    task automatic do_reset(input int n);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        mem_q.delete();
        repeat (n) step();
        reset         = 1'b0;
        rel_cyc       = cyc;
        first_req_cyc = -1;
        first_val_cyc = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_pc       = RESET_PC;

        // Streaming with single-cycle memory.
        lat = 1;
        do_reset(3);
        mark();
        repeat (10) step();
        check("t1_first_req_cycle", 32'(first_req_cyc), 32'(rel_cyc));
        check("t1_first_valid_latency", 32'(first_val_cyc - first_req_cyc), 2);
        check("t1_back_to_back_requests", 32'(fires), 10);
        check("t1_first_pc", first_pop_pc, RESET_PC);

        // Core stalled: credits run out at DEPTH.
        instr_ready = 1'b0;
        do_reset(2);
        mark();
        repeat (10) step();
        check("t2_requests_issued", 32'(fires), DEPTH);
        check("t2_req_valid_low", 32'(last_req_valid), 0);
        check("t2_fifo_full", 32'(dut.fifo_full), 1);
        instr_ready = 1'b1;
        step();
        check("t2_first_pop_pc", first_pop_pc, RESET_PC);
        check("t2_no_req_in_pop_cycle", 32'(last_req_valid), 0);
        instr_ready = 1'b0;
        step();
        check("t2_req_resumes", 32'(last_req_valid), 1);
        instr_ready = 1'b1;
        repeat (6) step();

        // Redirect with three requests in flight, latency 3.
        lat = 3;
        do_reset(2);
        repeat (3) step();
        mark();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        check("t3_drop_cnt", 32'(dut.drop_cnt), 2);
        check("t3_state_drain", 32'(dut.state), 32'(FETCH_DRAIN));
        check("t3_next_req_addr", imem_req_addr, 32'h0000_0100);
        repeat (12) step();
        check("t3_first_pc", first_pop_pc, 32'h0000_0100);
        check("t3_state_run", 32'(dut.state), 32'(FETCH_RUN));

        // Redirect coinciding with a response, two live requests.
        do_reset(2);
        step();
        step();
        imem_req_ready = 1'b0;
        step();
        imem_req_ready = 1'b1;
        mark();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        check("t4_drop_cnt", 32'(dut.drop_cnt), 1);
        check("t4_outstanding", 32'(dut.outstanding), 0);
        step();
        check("t4_drop_done", 32'(dut.drop_cnt), 0);
        check("t4_state_run", 32'(dut.state), 32'(FETCH_RUN));
        repeat (10) step();
        check("t4_first_pc", first_pop_pc, 32'h0000_0040);

        // Back-to-back redirects.
        lat = 2;
        do_reset(2);
        repeat (4) step();
        mark();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_pc    = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        repeat (15) step();
        check("t5_no_0x200_fetch", 32'(bad_fires), 0);
        check("t5_first_pc", first_pop_pc, 32'h0000_0300);

        // Random request/consume stalls, then reset mid-stream.
        do_reset(2);
        for (int i = 0; i < 60; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            instr_ready    = 1'($urandom_range(0, 1));
            step();
        end
        do_reset(3);
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        mark();
        repeat (8) step();
        check("t6_restart_cycle", 32'(first_req_cyc), 32'(rel_cyc));
        check("t6_restart_pc", first_pop_pc, RESET_PC);

        imem_req_ready = 1'b0;
        repeat (10) step();
        check("end_outstanding", 32'(dut.outstanding), 0);
        check("end_drop_cnt", 32'(dut.drop_cnt), 0);
        check("end_instr_valid", 32'(instr_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
